// File: rtl/shift_acc.sv
// Frame accumulator behind the saturating shifter: sums COUNT 9-bit samples into a
// saturating ACC_W-bit total, counts saturated (9'h1FF) samples, and hands the frame on.
module shift_acc #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_sat_cnt,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [7:0] LAST = 8'(COUNT);

  state_t           state, state_nx;
  logic [ACC_W-1:0] sum, sum_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [7:0]       sat, sat_nx;
  logic             ovf, ovf_nx;

  logic             accept;
  logic             is_sat;
  logic [ACC_W:0]   ext;
  logic [ACC_W:0]   t;

  assign in_ready = (state != HOLD) && !rst;
  assign accept   = in_valid && in_ready && !clr;
  assign is_sat   = (in_res == 9'h1FF);
  assign ext      = {{(ACC_W - 8){1'b0}}, in_res};
  assign t        = {1'b0, sum} + ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      cnt   <= '0;
      sat   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      sum   <= sum_nx;
      cnt   <= cnt_nx;
      sat   <= sat_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sum_nx   = sum;
    cnt_nx   = cnt;
    sat_nx   = sat;
    ovf_nx   = ovf;

    case (state)
      IDLE: begin
        if (accept) begin
          sum_nx   = ext[ACC_W-1:0];
          cnt_nx   = 8'd1;
          sat_nx   = {7'd0, is_sat};
          ovf_nx   = 1'b0;
          state_nx = (LAST == 8'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Carry out of the ACC_W+1-bit add means the frame total clipped.
          if (t[ACC_W]) begin
            sum_nx = '1;
            ovf_nx = 1'b1;
          end else begin
            sum_nx = t[ACC_W-1:0];
          end
          sat_nx = sat + {7'd0, is_sat};
          cnt_nx = cnt + 8'd1;
          if (cnt + 8'd1 == LAST) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nx = IDLE;
          sum_nx   = '0;
          cnt_nx   = '0;
          sat_nx   = '0;
          ovf_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort overrides both a same-cycle accept and a same-cycle delivery.
    if (clr) begin
      state_nx = IDLE;
      sum_nx   = '0;
      cnt_nx   = '0;
      sat_nx   = '0;
      ovf_nx   = 1'b0;
    end
  end

  assign out_valid   = (state == HOLD);
  assign out_sum     = out_valid ? sum : '0;
  assign out_sat_cnt = out_valid ? sat : '0;
  assign out_ovf     = out_valid && ovf;
  assign busy        = (state != IDLE);

endmodule
